mem_stage: RTL

Memory stage of the core pipeline: accepts one instruction per handshake from the execute stage (ALU result used as effective address), performs loads/stores on the data-memory request/grant/rvalid bus, and hands a register-writeback record to the writeback stage. Handles byte/half/word lanes, load sign/zero extension, misalignment detection and pipeline back-pressure with a small FSM and one output register.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/mem_align.sv | 57 +++++
 rtl/mem_stage.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory stage: op encoding, funct3 size codes,
// FSM states and the writeback record.
package mem_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned RF_AW = 5;

   typedef enum logic [1:0] {
      MemNone  = 2'b00,
      MemLoad  = 2'b01,
      MemStore = 2'b10
   } mem_op_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StReq   = 2'b01,
      StWaitR = 2'b10
   } mem_state_t;

   typedef struct packed {
      logic [RF_AW-1:0] rd;
      logic [XLEN-1:0]  data;
      logic             reg_write;
   } mem_result_t;

endpackage

// File: rtl/mem_align.sv
// Lane logic: store byte enables / replicated write data, load lane extraction with
// sign/zero extension, and the misaligned/illegal access flag.
module mem_align
   import mem_pkg::*;
(
   input  logic [1:0]      i_lane,
   input  logic [2:0]      i_funct3,
   input  logic            i_store,
   input  logic [XLEN-1:0] i_store_data,
   input  logic [XLEN-1:0] i_load_data,
   output logic [3:0]      o_be,
   output logic [XLEN-1:0] o_wdata,
   output logic [XLEN-1:0] o_load_data,
   output logic            o_misalign
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_load_data[{i_lane, 3'b000} +: 8];
   assign w_half = i_lane[1] ? i_load_data[31:16] : i_load_data[15:0];

   always_comb begin
      o_be        = 4'b0000;
      o_wdata     = i_store_data;
      o_load_data = i_load_data;
      o_misalign  = 1'b0;
      case (i_funct3)
         F3_B: begin
            o_be        = 4'b0001 << i_lane;
            o_wdata     = {4{i_store_data[7:0]}};
            o_load_data = {{24{w_byte[7]}}, w_byte};
         end
         F3_H: begin
            o_be        = 4'b0011 << i_lane;
            o_wdata     = {2{i_store_data[15:0]}};
            o_load_data = {{16{w_half[15]}}, w_half};
            o_misalign  = i_lane[0];
         end
         F3_W: begin
            o_be       = 4'hF;
            o_misalign = |i_lane;
         end
         // Unsigned variants only exist for loads; a store using them is illegal.
         F3_BU: begin
            o_load_data = {24'h0, w_byte};
            o_misalign  = i_store;
         end
         F3_HU: begin
            o_load_data = {16'h0, w_half};
            o_misalign  = i_lane[0] | i_store;
         end
         default: o_misalign = 1'b1;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: one instruction per handshake, load/store over the
// req/gnt/rvalid data bus, single output register towards writeback.
module mem_stage
   import mem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned NUM_REGISTERS = 32,
   localparam int unsigned ADDRESS_WIDTH = $clog2(NUM_REGISTERS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ex_valid_in,
   output logic                      ex_ready_out,
   input  logic [DATA_WIDTH-1:0]     alu_result_in,
   input  logic [DATA_WIDTH-1:0]     rs2_data_in,
   input  logic [ADDRESS_WIDTH-1:0]  rd_in,
   input  logic                      reg_write_in,
   input  mem_op_t                   mem_op_in,
   input  logic [2:0]                funct3_in,
   output logic                      dmem_req_out,
   output logic                      dmem_we_out,
   output logic [DATA_WIDTH-1:0]     dmem_addr_out,
   output logic [DATA_WIDTH-1:0]     dmem_wdata_out,
   output logic [DATA_WIDTH/8-1:0]   dmem_be_out,
   input  logic                      dmem_gnt_in,
   input  logic                      dmem_rvalid_in,
   input  logic [DATA_WIDTH-1:0]     dmem_rdata_in,
   output logic                      wb_valid_out,
   input  logic                      wb_ready_in,
   output logic [ADDRESS_WIDTH-1:0]  wb_rd_out,
   output logic [DATA_WIDTH-1:0]     wb_data_out,
   output logic                      wb_reg_write_out,
   output logic                      misalign_exc_out
);

   if (DATA_WIDTH != 32) begin : g_bad_data_width
      $error("mem_stage: only DATA_WIDTH=32 is supported");
   end
   if (ADDRESS_WIDTH != RF_AW) begin : g_bad_rf_size
      $error("mem_stage: NUM_REGISTERS must give a 5-bit register index");
   end

   mem_state_t               r_state, w_state_d;
   logic [DATA_WIDTH-1:0]    r_addr, r_wdata;
   logic [3:0]               r_be;
   logic                     r_we;
   logic [1:0]               r_lane;
   logic [2:0]               r_funct3;
   logic [ADDRESS_WIDTH-1:0] r_rd;
   logic                     r_reg_write;
   mem_result_t              r_res, w_res_d;
   logic                     r_wb_valid, w_wb_valid_d;
   logic                     r_misalign, w_misalign_d;

   logic                     w_accept, w_capture, w_res_load;
   logic [1:0]               w_lane;
   logic [2:0]               w_funct3;
   logic [3:0]               w_be;
   logic [DATA_WIDTH-1:0]    w_wdata, w_load_data;
   logic                     w_misalign;

   assign ex_ready_out = (r_state == StIdle) && (!r_wb_valid || wb_ready_in);
   assign w_accept     = ex_valid_in && ex_ready_out;

   // Shared aligner: decodes the incoming op in IDLE, the captured op while waiting.
   assign w_lane   = (r_state == StIdle) ? alu_result_in[1:0] : r_lane;
   assign w_funct3 = (r_state == StIdle) ? funct3_in : r_funct3;

   mem_align u_align (
      .i_lane       (w_lane),
      .i_funct3     (w_funct3),
      .i_store      (mem_op_in == MemStore),
      .i_store_data (rs2_data_in),
      .i_load_data  (dmem_rdata_in),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .o_load_data  (w_load_data),
      .o_misalign   (w_misalign)
   );

   always_comb begin
      w_state_d    = r_state;
      w_capture    = 1'b0;
      w_res_load   = 1'b0;
      w_res_d      = r_res;
      w_misalign_d = 1'b0;
      case (r_state)
         StIdle: begin
            if (w_accept) begin
               if (mem_op_in == MemLoad || mem_op_in == MemStore) begin
                  if (w_misalign) begin
                     w_res_load   = 1'b1;
                     w_res_d      = '{rd: rd_in, data: alu_result_in, reg_write: 1'b0};
                     w_misalign_d = 1'b1;
                  end else begin
                     w_capture = 1'b1;
                     w_state_d = StReq;
                  end
               end else begin
                  w_res_load = 1'b1;
                  w_res_d    = '{rd: rd_in, data: alu_result_in, reg_write: reg_write_in};
               end
            end
         end
         StReq: begin
            if (dmem_gnt_in) begin
               if (r_we) begin
                  w_res_load = 1'b1;
                  w_res_d    = '{rd: r_rd, data: '0, reg_write: 1'b0};
                  w_state_d  = StIdle;
               end else begin
                  w_state_d = StWaitR;
               end
            end
         end
         StWaitR: begin
            if (dmem_rvalid_in) begin
               w_res_load = 1'b1;
               w_res_d    = '{rd: r_rd, data: w_load_data, reg_write: r_reg_write};
               w_state_d  = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
      w_wb_valid_d = w_res_load || (r_wb_valid && !wb_ready_in);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StIdle;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_be        <= '0;
         r_we        <= 1'b0;
         r_lane      <= '0;
         r_funct3    <= '0;
         r_rd        <= '0;
         r_reg_write <= 1'b0;
         r_res       <= '0;
         r_wb_valid  <= 1'b0;
         r_misalign  <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_wb_valid <= w_wb_valid_d;
         r_misalign <= w_misalign_d;
         if (w_capture) begin
            r_addr      <= {alu_result_in[DATA_WIDTH-1:2], 2'b00};
            r_we        <= (mem_op_in == MemStore);
            r_be        <= w_be;
            r_wdata     <= w_wdata;
            r_lane      <= alu_result_in[1:0];
            r_funct3    <= funct3_in;
            r_rd        <= rd_in;
            r_reg_write <= reg_write_in;
         end
         if (w_res_load) begin
            r_res <= w_res_d;
         end
      end
   end

   assign dmem_req_out     = (r_state == StReq);
   assign dmem_we_out      = r_we;
   assign dmem_addr_out    = r_addr;
   assign dmem_wdata_out   = r_wdata;
   assign dmem_be_out      = r_be;
   assign wb_valid_out     = r_wb_valid;
   assign wb_rd_out        = r_res.rd;
   assign wb_data_out      = r_res.data;
   assign wb_reg_write_out = r_res.reg_write;
   assign misalign_exc_out = r_misalign;

endmodule
